// File: rtl/uart_cfg_pkg.sv
// -----------------------------------------------------------------------------
// uart_cfg_pkg
// Shared definitions for the UART configuration frame controller:
//   - frame header bytes (0x55, 0xAA)
//   - register addresses of the configuration map
//   - the frame-parser FSM state type
//   - the frame checksum helper (8-bit modular sum of ADDR, DHI, DLO)
// -----------------------------------------------------------------------------
package uart_cfg_pkg;

  // Frame header
  localparam logic [7:0] HDR_BYTE0 = 8'h55;
  localparam logic [7:0] HDR_BYTE1 = 8'hAA;

  // Register map
  localparam logic [7:0] ADDR_K   = 8'h00;  // K          <= DLO[3:0]
  localparam logic [7:0] ADDR_UD  = 8'h01;  // Up_or_down <= DLO[1:0]
  localparam logic [7:0] ADDR_FS  = 8'h02;  // Sample_fs  <= {DHI, DLO}

  // Each state names the byte the parser is waiting for next.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR2 = 3'd1,
    ST_ADDR = 3'd2,
    ST_DHI  = 3'd3,
    ST_DLO  = 3'd4,
    ST_CSUM = 3'd5
  } state_t;

  // Checksum is the byte-wide sum of the payload; carries are dropped.
  function automatic logic [7:0] frame_csum(input logic [7:0] addr,
                                            input logic [7:0] d_hi,
                                            input logic [7:0] d_lo);
    return addr + d_hi + d_lo;
  endfunction

endpackage

// File: rtl/uart_cfg_timeout.sv
// -----------------------------------------------------------------------------
// uart_cfg_timeout
// Inter-byte timeout counter for the frame parser.
//
// Ports:
//   i_clk     system clock, rising edge
//   i_rst     asynchronous active-high reset
//   i_clear   restart the count (a byte arrived); also suppresses expiry
//   i_run     count while high (a frame is partially received)
//   o_expire  high for the cycle in which the counter sits at TIMEOUT_CYCLES-1
//
// The counter restarts from zero after expiry, when cleared, and whenever it
// is not running, so it always measures the gap since the last byte.
// -----------------------------------------------------------------------------
module uart_cfg_timeout #(
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_expire;

  // A clear in the expiry cycle wins: the byte is processed, no timeout.
  assign w_expire = i_run && !i_clear && (r_cnt == LAST_COUNT);
  assign o_expire = w_expire;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear || !i_run || w_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cfg_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cfg_frame_ctrl
// Parses 6-byte configuration frames from a UART byte receiver and writes a
// small register bank driving the analog switch and DSP configuration.
//
// Frame: 0x55, 0xAA, ADDR, DHI, DLO, CSUM   with CSUM = (ADDR+DHI+DLO) mod 256
//
// Ports:
//   Clk          system clock, rising edge
//   Reset        asynchronous active-high reset
//   Rx_data[7:0] received byte, meaningful only while Rx_done is high
//   Rx_done      one-cycle "byte valid" strobe
//   K[3:0]       analog switch control word        (addr 0x00)
//   Up_or_down   DSP direction/mode select          (addr 0x01)
//   Sample_fs    sample-rate divider, never 0       (addr 0x02)
//   Cfg_update   one-cycle pulse on a register write
//   Frame_err    one-cycle pulse on checksum/address/value/timeout error
//   Busy         a frame is partially received
//   o_dbg_state  current parser state (uart_cfg_pkg::state_t encoding)
//
// Handshake: the byte interface is valid-only. Rx_done high for one cycle
// means Rx_data holds a new byte that must be consumed in that cycle; there is
// no ready/back-pressure, and the parser accepts a byte on every cycle,
// including back-to-back frames with no idle gap.
//
// Results of a frame (register write, Cfg_update, Frame_err) are registered
// and become visible on the edge that consumes the CSUM byte.
// -----------------------------------------------------------------------------
module uart_cfg_frame_ctrl
  import uart_cfg_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 500000,
  parameter logic [3:0]  K_RST          = 4'h0,
  parameter logic [15:0] FS_RST         = 16'd1000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  Rx_data,
  input  logic        Rx_done,
  output logic [3:0]  K,
  output logic [1:0]  Up_or_down,
  output logic [15:0] Sample_fs,
  output logic        Cfg_update,
  output logic        Frame_err,
  output logic        Busy,
  output logic [2:0]  o_dbg_state
);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t      r_state;
  logic [7:0]  r_addr;
  logic [7:0]  r_dhi;
  logic [7:0]  r_dlo;
  logic [3:0]  r_k;
  logic [1:0]  r_up_or_down;
  logic [15:0] r_sample_fs;
  logic        r_cfg_update;
  logic        r_frame_err;

  // ---------------------------------------------------------------------------
  // Combinational controls
  // ---------------------------------------------------------------------------
  state_t      w_next_state;
  logic        w_lat_addr;
  logic        w_lat_dhi;
  logic        w_lat_dlo;
  logic        w_wr_k;
  logic        w_wr_ud;
  logic        w_wr_fs;
  logic        w_err;
  logic        w_run;
  logic        w_expire;
  logic [7:0]  w_csum;
  logic [15:0] w_fs_value;

  assign w_run      = (r_state != ST_IDLE);
  assign w_csum     = frame_csum(r_addr, r_dhi, r_dlo);
  assign w_fs_value = {r_dhi, r_dlo};

  uart_cfg_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (Clk),
    .i_rst    (Reset),
    .i_clear  (Rx_done),
    .i_run    (w_run),
    .o_expire (w_expire)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_lat_addr   = 1'b0;
    w_lat_dhi    = 1'b0;
    w_lat_dlo    = 1'b0;
    w_wr_k       = 1'b0;
    w_wr_ud      = 1'b0;
    w_wr_fs      = 1'b0;
    w_err        = 1'b0;

    if (Rx_done) begin
      unique case (r_state)
        ST_IDLE: begin
          // Line noise between frames is dropped silently.
          if (Rx_data == HDR_BYTE0) w_next_state = ST_HDR2;
        end
        ST_HDR2: begin
          // A repeated 0x55 may be the real start of a frame: stay put.
          if (Rx_data == HDR_BYTE1)      w_next_state = ST_ADDR;
          else if (Rx_data == HDR_BYTE0) w_next_state = ST_HDR2;
          else                           w_next_state = ST_IDLE;
        end
        ST_ADDR: begin
          w_lat_addr   = 1'b1;
          w_next_state = ST_DHI;
        end
        ST_DHI: begin
          w_lat_dhi    = 1'b1;
          w_next_state = ST_DLO;
        end
        ST_DLO: begin
          w_lat_dlo    = 1'b1;
          w_next_state = ST_CSUM;
        end
        ST_CSUM: begin
          w_next_state = ST_IDLE;
          if (Rx_data != w_csum) begin
            w_err = 1'b1;
          end else begin
            case (r_addr)
              ADDR_K:  w_wr_k  = 1'b1;
              ADDR_UD: w_wr_ud = 1'b1;
              ADDR_FS: begin
                // A zero divider would stall the sample clock.
                if (w_fs_value == 16'd0) w_err   = 1'b1;
                else                     w_wr_fs = 1'b1;
              end
              default: w_err = 1'b1;
            endcase
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end else if (w_expire) begin
      // Stalled frame: abandon it and report once.
      w_next_state = ST_IDLE;
      w_err        = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: latched frame bytes, config registers, result pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_addr       <= 8'h00;
      r_dhi        <= 8'h00;
      r_dlo        <= 8'h00;
      r_k          <= K_RST;
      r_up_or_down <= 2'b00;
      r_sample_fs  <= FS_RST;
      r_cfg_update <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if (w_lat_addr) r_addr <= Rx_data;
      if (w_lat_dhi)  r_dhi  <= Rx_data;
      if (w_lat_dlo)  r_dlo  <= Rx_data;

      // Only the low bits of DLO matter for the narrow registers.
      if (w_wr_k)  r_k          <= r_dlo[3:0];
      if (w_wr_ud) r_up_or_down <= r_dlo[1:0];
      if (w_wr_fs) r_sample_fs  <= w_fs_value;

      r_cfg_update <= w_wr_k | w_wr_ud | w_wr_fs;
      r_frame_err  <= w_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign K           = r_k;
  assign Up_or_down  = r_up_or_down;
  assign Sample_fs   = r_sample_fs;
  assign Cfg_update  = r_cfg_update;
  assign Frame_err   = r_frame_err;
  assign Busy        = w_run;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_cfg_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_cfg_frame_ctrl
// Self-checking bench for uart_cfg_frame_ctrl (TIMEOUT_CYCLES = 16).
// Each frame sent pushes its expected result (pulse kind + register snapshot)
// onto exp_q; a monitor pops and compares whenever Cfg_update or Frame_err
// pulses. Scenario tasks add direct checks on timing and register values.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_cfg_frame_ctrl;
  import uart_cfg_pkg::*;

  localparam int          TO     = 16;
  localparam logic [3:0]  K_R    = 4'h0;
  localparam logic [15:0] FS_R   = 16'd1000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [3:0]  k;
  logic [1:0]  ud;
  logic [15:0] fs;
  logic        cfg_update;
  logic        frame_err;
  logic        busy;
  logic [2:0]  dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_cfg_frame_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .K_RST          (K_R),
    .FS_RST         (FS_R)
  ) dut (
    .Clk         (clk),
    .Reset       (rst),
    .Rx_data     (rx_data),
    .Rx_done     (rx_done),
    .K           (k),
    .Up_or_down  (ud),
    .Sample_fs   (fs),
    .Cfg_update  (cfg_update),
    .Frame_err   (frame_err),
    .Busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          err_seen = 0;
  int          cfg_seen = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_obs;
  logic [23:0] mon_exp;
  logic [3:0]  m_k;
  logic [1:0]  m_ud;
  logic [15:0] m_fs;

  // Snapshot layout: {Cfg_update, Frame_err, K, Up_or_down, Sample_fs}
  always @(negedge clk) begin
    if (!rst && (cfg_update || frame_err)) begin
      mon_obs = {cfg_update, frame_err, k, ud, fs};
      if (frame_err)  err_seen++;
      if (cfg_update) cfg_seen++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_pulse: got %h, expected no pulse", mon_obs);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_obs !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_result: got %h, expected %h", mon_obs, mon_exp);
        end
      end
    end
  end

  // Apply a frame to the model and queue the pulse it should produce.
  task automatic model_frame(input logic [7:0] a, input logic [7:0] dh,
                             input logic [7:0] dl, input logic [7:0] cs);
    logic [7:0] s;
    logic       ok;
    s  = a + dh + dl;
    ok = (cs == s);
    if (ok && a == 8'h00)                        m_k  = dl[3:0];
    else if (ok && a == 8'h01)                   m_ud = dl[1:0];
    else if (ok && a == 8'h02 && {dh, dl} != 0)  m_fs = {dh, dl};
    else                                         ok   = 1'b0;
    exp_q.push_back({ok, !ok, m_k, m_ud, m_fs});
  endtask

  task automatic model_reset();
    m_k  = K_R;
    m_ud = 2'b00;
    m_fs = FS_R;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called on a falling edge, return on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_done = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Leaves rx_done high so another frame can follow with no gap.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] dh,
                            input logic [7:0] dl, input logic [7:0] cs);
    model_frame(a, dh, dl, cs);
    send_byte(HDR_BYTE0);
    send_byte(HDR_BYTE1);
    send_byte(a);
    send_byte(dh);
    send_byte(dl);
    send_byte(cs);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    n_checks++; if (k !== K_R) begin n_fail++; $display("FAIL rst_k: got %h, expected %h", k, K_R); end
    n_checks++; if (ud !== 2'b00) begin n_fail++; $display("FAIL rst_ud: got %b, expected 00", ud); end
    n_checks++; if (fs !== FS_R) begin n_fail++; $display("FAIL rst_fs: got %0d, expected %0d", fs, FS_R); end
    n_checks++; if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_update: got %b, expected 0", cfg_update); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_frame_err: got %b, expected 0", frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d, expected 0", dbg_state); end
  endtask

  task automatic test_write_k();
    send_frame(8'h00, 8'h00, 8'h05, 8'h05);
    // One edge after the CSUM byte: write and pulse already visible.
    n_checks++; if (cfg_update !== 1'b1) begin n_fail++; $display("FAIL wk_cfg_update: got %b, expected 1", cfg_update); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL wk_frame_err: got %b, expected 0", frame_err); end
    n_checks++; if (k !== 4'h5) begin n_fail++; $display("FAIL wk_k: got %h, expected 5", k); end
    idle(1);
    n_checks++; if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL wk_pulse_width: got %b, expected 0", cfg_update); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wk_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_sample_fs();
    send_frame(8'h02, 8'h01, 8'hF4, 8'hF7);
    n_checks++; if (fs !== 16'd500) begin n_fail++; $display("FAIL fs_write: got %0d, expected 500", fs); end
    send_frame(8'h02, 8'h00, 8'h00, 8'h02);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL fs_zero_err: got %b, expected 1", frame_err); end
    n_checks++; if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL fs_zero_cfg: got %b, expected 0", cfg_update); end
    n_checks++; if (fs !== 16'd500) begin n_fail++; $display("FAIL fs_zero_hold: got %0d, expected 500", fs); end
    idle(2);
  endtask

  task automatic test_bad_frames();
    send_frame(8'h01, 8'h00, 8'h02, 8'h04);   // checksum should be 03
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL bad_csum_err: got %b, expected 1", frame_err); end
    n_checks++; if (ud !== 2'b00) begin n_fail++; $display("FAIL bad_csum_ud: got %b, expected 00", ud); end
    send_frame(8'h03, 8'h00, 8'h01, 8'h04);   // valid checksum, unknown address
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL bad_addr_err: got %b, expected 1", frame_err); end
    n_checks++; if ({k, ud, fs} !== {4'h5, 2'b00, 16'd500}) begin
      n_fail++; $display("FAIL bad_addr_regs: got %h/%b/%0d, expected 5/00/500", k, ud, fs);
    end
    idle(2);
  endtask

  task automatic test_resync();
    model_frame(8'h00, 8'h00, 8'h03, 8'h03);
    send_byte(8'h55);
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h03);
    n_checks++; if (k !== 4'h3) begin n_fail++; $display("FAIL resync_k: got %h, expected 3", k); end
    idle(2);
  endtask

  task automatic test_noise_and_high_bits();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == HDR_BYTE0) b = 8'h00;
      send_byte(b);
    end
    idle(1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL noise_busy: got %b, expected 0", busy); end
    // High bits of DHI/DLO must not leak into narrow registers.
    send_frame(8'h01, 8'hFF, 8'hFE, 8'hFE);
    n_checks++; if (ud !== 2'b10) begin n_fail++; $display("FAIL hibits_ud: got %b, expected 10", ud); end
    send_frame(8'h00, 8'hA0, 8'hF7, 8'h97);
    n_checks++; if (k !== 4'h7) begin n_fail++; $display("FAIL hibits_k: got %h, expected 7", k); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, dh, dl, cs;
    for (int i = 0; i < 8; i++) begin
      a  = 8'($urandom_range(0, 2));
      dh = 8'($urandom_range(0, 255));
      dl = 8'($urandom_range(0, 255));
      cs = a + dh + dl;
      if (i == 4) cs = cs ^ 8'h01;
      send_frame(a, dh, dl, cs);
    end
    idle(3);
    n_checks++; if ({k, ud, fs} !== {m_k, m_ud, m_fs}) begin
      n_fail++; $display("FAIL b2b_regs: got %h/%b/%0d, expected %h/%b/%0d", k, ud, fs, m_k, m_ud, m_fs);
    end
  endtask

  task automatic test_timeout();
    int e0;
    int waited;
    e0 = err_seen;
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h00);
    idle(10);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL to_busy_mid: got %b, expected 1", busy); end
    n_checks++; if (err_seen !== e0) begin n_fail++; $display("FAIL to_early: got %0d errors, expected %0d", err_seen, e0); end
    exp_q.push_back({1'b0, 1'b1, m_k, m_ud, m_fs});
    waited = 0;
    while (err_seen == e0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_checks++; if (err_seen == e0) begin n_fail++; $display("FAIL to_wait: got no error in 40 cycles, expected one"); end
    idle(TO + 4);
    n_checks++; if (err_seen !== e0 + 1) begin n_fail++; $display("FAIL to_count: got %0d errors, expected %0d", err_seen - e0, 1); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_busy_after: got %b, expected 0", busy); end
    n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL to_state: got %0d, expected 0", dbg_state); end
    send_frame(8'h00, 8'h00, 8'h09, 8'h09);
    n_checks++; if (k !== 4'h9) begin n_fail++; $display("FAIL to_recover_k: got %h, expected 9", k); end
    idle(2);
  endtask

  // The DHI byte lands exactly in the expiry cycle: it must win.
  task automatic test_timeout_race();
    int e0;
    e0 = err_seen;
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h01);
    idle(TO - 1);
    model_frame(8'h01, 8'h00, 8'h01, 8'h02);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    n_checks++; if (ud !== 2'b01) begin n_fail++; $display("FAIL race_ud: got %b, expected 01", ud); end
    idle(2);
    n_checks++; if (err_seen !== e0) begin n_fail++; $display("FAIL race_err: got %0d errors, expected 0", err_seen - e0); end
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    int c0;
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h00);
    idle(1);
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++; if ({k, ud, fs} !== {K_R, 2'b00, FS_R}) begin
      n_fail++; $display("FAIL mrst_async_regs: got %h/%b/%0d, expected %h/00/%0d", k, ud, fs, K_R, FS_R);
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy: got %b, expected 0", busy); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    e0 = err_seen;
    c0 = cfg_seen;
    idle(TO + 8);
    n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL mrst_state: got %0d, expected 0", dbg_state); end
    n_checks++; if ((err_seen - e0) + (cfg_seen - c0) !== 0) begin
      n_fail++; $display("FAIL mrst_pulses: got %0d pulses, expected 0", (err_seen - e0) + (cfg_seen - c0));
    end
    n_checks++; if ({k, ud, fs} !== {K_R, 2'b00, FS_R}) begin
      n_fail++; $display("FAIL mrst_regs_after: got %h/%b/%0d, expected %h/00/%0d", k, ud, fs, K_R, FS_R);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    rst     = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    test_reset();
    test_write_k();
    test_sample_fs();
    test_bad_frames();
    test_resync();
    test_noise_and_high_bits();
    test_back_to_back();
    test_timeout();
    test_timeout_race();
    test_reset_mid_frame();

    idle(4);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_missing: got %0d results outstanding, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion in time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
